rmii_rx_decoder: RTL and testbench

- MAC-side consumer of the RMII receive path. Takes the 2-bit RMII receive data and CRS_DV, already registered into the RMII clock domain by the PHY interface.
- Aligns on preamble/SFD, assembles dibits LSB-first into bytes, and resolves CRS_DV toggling at end of carrier. Supports 10 and 100 Mbps.
- Output is a byte-strobe stream with frame-end and error indications, feeding the MAC receive framer.

---
 rtl/rmii_rx_decoder_pkg.sv | 25 ++
 rtl/rmii_sample_gen.sv | 28 ++
 rtl/rmii_rx_decoder.sv | 162 ++++++++++++++++
 tb/tb_rmii_rx_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rmii_rx_decoder_pkg.sv
// Shared constants and state type for the RMII receive decoder and its sample generator.
package rmii_rx_decoder_pkg;

  // Dibit codes seen during preamble/SFD alignment
  localparam logic [1:0] DIBIT_PRE = 2'b01;
  localparam logic [1:0] DIBIT_SFD = 2'b11;
  localparam logic [1:0] DIBIT_FC  = 2'b10;

  // 10 Mbps: one dibit spans 10 reference clocks; sample in the middle
  localparam logic [3:0] SAMPLE_LAST = 4'd9;
  localparam logic [3:0] SAMPLE_MID  = 4'd4;

  // state            | meaning
  // ST_IDLE          | no carrier, waiting for crs_dv
  // ST_PREAMBLE      | carrier up, hunting for SFD tail (11)
  // ST_DATA          | assembling dibits into bytes
  // ST_FALSE_CARRIER | bad preamble seen, waiting for carrier to drop
  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_PREAMBLE      = 2'd1,
    ST_DATA          = 2'd2,
    ST_FALSE_CARRIER = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rmii_sample_gen.sv
// Dibit sample strobe for RMII: every clock at 100 Mbps, mid-symbol once per
// 10 clocks at 10 Mbps. Shared with the transmit encoder.
module rmii_sample_gen
  import rmii_rx_decoder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_speed_100,
  input  logic i_restart,
  output logic o_sample
);

  logic [3:0] r_cnt;

  // Symbol-phase counter, realigned to the carrier edge on restart
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (i_restart || (r_cnt == SAMPLE_LAST)) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_sample = i_speed_100 | (r_cnt == SAMPLE_MID);

endmodule

// File: rtl/rmii_rx_decoder.sv
// RMII receive decoder: preamble/SFD alignment, LSB-first byte assembly and
// resolution of the CRS_DV toggle at end of carrier.
module rmii_rx_decoder
  import rmii_rx_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       speed_100,
  input  logic [1:0] rmii_rxd,
  input  logic       rmii_crs_dv,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_end,
  output logic       rx_er
);

  rx_state_e  r_state, w_state_nxt;
  logic       r_speed_100, w_speed_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic       r_pend, w_pend_nxt;
  logic [1:0] r_pend_dibit, w_pend_dibit_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_end, w_end_nxt;
  logic       r_er, w_er_nxt;
  logic       w_restart;
  logic       w_sample;
  logic       w_step;
  logic [7:0] w_shift_a;
  logic [1:0] w_idx_a;

  rmii_sample_gen u_sample_gen (
    .clk         (clk),
    .rst         (rst),
    .i_speed_100 (r_speed_100),
    .i_restart   (w_restart),
    .o_sample    (w_sample)
  );

  // IDLE watches every clock so the 10M phase can be aligned to the carrier edge
  assign w_step = (r_state == ST_IDLE) || w_sample;

  // State and datapath registers; output strobes last one clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_speed_100  <= 1'b0;
      r_shift      <= 8'd0;
      r_idx        <= 2'd0;
      r_pend       <= 1'b0;
      r_pend_dibit <= 2'd0;
      r_data       <= 8'd0;
      r_valid      <= 1'b0;
      r_end        <= 1'b0;
      r_er         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_speed_100  <= w_speed_nxt;
      r_shift      <= w_shift_nxt;
      r_idx        <= w_idx_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_dibit <= w_pend_dibit_nxt;
      r_data       <= w_data_nxt;
      r_valid      <= w_valid_nxt;
      r_end        <= w_end_nxt;
      r_er         <= w_er_nxt;
    end
  end

  // Next-state, dibit assembly and strobe generation
  always_comb begin
    w_state_nxt      = r_state;
    w_speed_nxt      = r_speed_100;
    w_shift_nxt      = r_shift;
    w_idx_nxt        = r_idx;
    w_pend_nxt       = r_pend;
    w_pend_dibit_nxt = r_pend_dibit;
    w_data_nxt       = r_data;
    w_valid_nxt      = 1'b0;
    w_end_nxt        = 1'b0;
    w_er_nxt         = 1'b0;
    w_restart        = 1'b0;
    w_shift_a        = r_shift;
    w_idx_a          = r_idx;

    if (w_step) begin
      case (r_state)
        ST_IDLE: begin
          if (rmii_crs_dv) begin
            w_state_nxt = ST_PREAMBLE;
            w_speed_nxt = speed_100;
            w_restart   = 1'b1;
            w_pend_nxt  = 1'b0;
            w_idx_nxt   = 2'd0;
          end
        end

        ST_PREAMBLE: begin
          if (!rmii_crs_dv) begin
            w_state_nxt = ST_IDLE;
          end else if (rmii_rxd == DIBIT_SFD) begin
            w_state_nxt = ST_DATA;
            w_idx_nxt   = 2'd0;
            w_pend_nxt  = 1'b0;
          end else if (rmii_rxd == DIBIT_FC) begin
            w_state_nxt = ST_FALSE_CARRIER;
            w_end_nxt   = 1'b1;
            w_er_nxt    = 1'b1;
          end else if (rmii_rxd == DIBIT_PRE) begin
            w_state_nxt = ST_PREAMBLE;
          end
        end

        ST_FALSE_CARRIER: begin
          if (!rmii_crs_dv) begin
            w_state_nxt = ST_IDLE;
          end
        end

        ST_DATA: begin
          if (rmii_crs_dv) begin
            // A held dibit turned out to be a carrier toggle: it goes in first
            if (r_pend) begin
              w_shift_a = {r_pend_dibit, r_shift[7:2]};
              w_idx_a   = r_idx + 2'd1;
            end
            w_shift_nxt = {rmii_rxd, w_shift_a[7:2]};
            w_idx_nxt   = w_idx_a + 2'd1;
            w_pend_nxt  = 1'b0;
            if (w_idx_a == 2'd3) begin
              w_data_nxt  = w_shift_nxt;
              w_valid_nxt = 1'b1;
            end
          end else if (r_pend) begin
            // Second low sample: carrier really ended; a half byte is an error
            w_state_nxt = ST_IDLE;
            w_pend_nxt  = 1'b0;
            w_end_nxt   = 1'b1;
            w_er_nxt    = (r_idx == 2'd2);
          end else if (!r_idx[0]) begin
            w_pend_nxt       = 1'b1;
            w_pend_dibit_nxt = rmii_rxd;
          end else begin
            // Carrier dropped on an odd dibit, which a compliant PHY never does
            w_state_nxt = ST_IDLE;
            w_end_nxt   = 1'b1;
            w_er_nxt    = 1'b1;
          end
        end

        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign rx_data  = r_data;
  assign rx_valid = r_valid;
  assign rx_end   = r_end;
  assign rx_er    = r_er;

endmodule

// File: tb/tb_rmii_rx_decoder.sv
// Directed bench for rmii_rx_decoder: frames at both speeds, carrier toggles,
// partial bytes, false carrier and mid-frame reset.
module tb_rmii_rx_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       speed_100;
  logic [1:0] rmii_rxd;
  logic       rmii_crs_dv;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_end;
  logic       rx_er;

  int n_checks = 0;
  int n_pass   = 0;
  int hold     = 1;
  int cyc      = 0;
  int n_coinc  = 0;

  logic [7:0] vq_data[$];
  int         vq_cyc[$];
  logic       eq_er[$];
  int         eq_cyc[$];

  rmii_rx_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .speed_100   (speed_100),
    .rmii_rxd    (rmii_rxd),
    .rmii_crs_dv (rmii_crs_dv),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_end      (rx_end),
    .rx_er       (rx_er)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record strobes away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        vq_data.push_back(rx_data);
        vq_cyc.push_back(cyc);
      end
      if (rx_end) begin
        eq_er.push_back(rx_er);
        eq_cyc.push_back(cyc);
      end
      if (rx_valid && rx_end) n_coinc = n_coinc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_q();
    vq_data.delete();
    vq_cyc.delete();
    eq_er.delete();
    eq_cyc.delete();
  endtask

  task automatic dib(input logic [1:0] d, input logic crs);
    rmii_rxd    = d;
    rmii_crs_dv = crs;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) dib(2'b00, 1'b0);
  endtask

  task automatic preamble();
    for (int i = 0; i < 31; i++) dib(2'b01, 1'b1);
    dib(2'b11, 1'b1);
  endtask

  task automatic byte_tx(input logic [7:0] b);
    for (int i = 0; i < 4; i++) dib(b[2*i +: 2], 1'b1);
  endtask

  // Carrier low on even dibits, high on odd ones
  task automatic byte_tx_toggle(input logic [7:0] b);
    for (int i = 0; i < 4; i++) dib(b[2*i +: 2], i[0]);
  endtask

  task automatic check_frame(input string tag, input int n_exp, input logic [31:0] exp_bytes,
                             input int n_end, input logic exp_er, input int val_gap, input int end_gap);
    check({tag, "_nvalid"}, 32'(vq_data.size()), 32'(n_exp));
    for (int i = 0; i < n_exp && i < vq_data.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(vq_data[i]), 32'(exp_bytes[8*i +: 8]));
    for (int i = 1; i < vq_cyc.size(); i++)
      check($sformatf("%s_vgap%0d", tag, i), 32'(vq_cyc[i] - vq_cyc[i-1]), 32'(val_gap));
    check({tag, "_nend"}, 32'(eq_er.size()), 32'(n_end));
    if (n_end > 0 && eq_er.size() > 0)
      check({tag, "_er"}, 32'(eq_er[0]), 32'(exp_er));
    if (end_gap >= 0 && vq_cyc.size() > 0 && eq_cyc.size() > 0)
      check({tag, "_endgap"}, 32'(eq_cyc[0] - vq_cyc[vq_cyc.size()-1]), 32'(end_gap));
  endtask

  initial begin
    rst         = 1'b1;
    speed_100   = 1'b1;
    rmii_rxd    = 2'b00;
    rmii_crs_dv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_end",   32'(rx_end),   32'd0);
    check("rst_er",    32'(rx_er),    32'd0);
    check("rst_data",  32'(rx_data),  32'd0);
    rst = 1'b0;
    idle(3);

    // 100M clean frame, end at byte boundary
    clear_q();
    preamble();
    byte_tx(8'h55); byte_tx(8'hD5); byte_tx(8'hA3);
    dib(2'b00, 1'b0); dib(2'b00, 1'b0);
    idle(4);
    check_frame("f100", 3, 32'h00A3D555, 1, 1'b0, 4, 2);

    // CRS_DV toggling across the last two bytes
    clear_q();
    preamble();
    byte_tx(8'h55); byte_tx(8'hD5);
    byte_tx_toggle(8'h12); byte_tx_toggle(8'h34);
    dib(2'b00, 1'b0); dib(2'b00, 1'b0);
    idle(4);
    check_frame("tog", 4, 32'h3412D555, 1, 1'b0, 4, 2);

    // Partial byte: two dibits of a 4th byte
    clear_q();
    preamble();
    byte_tx(8'h55); byte_tx(8'hD5); byte_tx(8'hA3);
    dib(2'b11, 1'b1); dib(2'b11, 1'b1);
    dib(2'b00, 1'b0); dib(2'b00, 1'b0);
    idle(4);
    check_frame("part", 3, 32'h00A3D555, 1, 1'b1, 4, 4);

    // Carrier lost on an odd dibit
    clear_q();
    preamble();
    byte_tx(8'h55);
    dib(2'b01, 1'b1);
    dib(2'b00, 1'b0);
    idle(4);
    check_frame("odd", 1, 32'h00000055, 1, 1'b1, 4, 2);

    // Zero-byte frame
    clear_q();
    preamble();
    dib(2'b00, 1'b0); dib(2'b00, 1'b0);
    idle(4);
    check_frame("zero", 0, 32'h0, 1, 1'b0, 4, -1);

    // 10M frame, speed_100 flipped mid-frame
    clear_q();
    speed_100 = 1'b0;
    hold      = 10;
    preamble();
    byte_tx(8'h55);
    speed_100 = 1'b1;
    byte_tx(8'hD5); byte_tx(8'hA3);
    dib(2'b00, 1'b0); dib(2'b00, 1'b0);
    idle(2);
    check_frame("f10", 3, 32'h00A3D555, 1, 1'b0, 40, 20);
    hold = 1;
    idle(3);

    // False carrier, then a good frame
    clear_q();
    for (int i = 0; i < 4; i++) dib(2'b01, 1'b1);
    dib(2'b10, 1'b1); dib(2'b10, 1'b1); dib(2'b10, 1'b1);
    dib(2'b01, 1'b1); dib(2'b11, 1'b1);
    dib(2'b00, 1'b0);
    idle(4);
    check_frame("fc", 0, 32'h0, 1, 1'b1, 4, -1);
    clear_q();
    preamble();
    byte_tx(8'h55); byte_tx(8'hD5); byte_tx(8'hA3);
    dib(2'b00, 1'b0); dib(2'b00, 1'b0);
    idle(4);
    check_frame("fc_next", 3, 32'h00A3D555, 1, 1'b0, 4, 2);

    // Reset mid-frame, then a good frame
    clear_q();
    preamble();
    byte_tx(8'h55); byte_tx(8'hD5);
    dib(2'b11, 1'b1);
    check("prerst_data", 32'(rx_data), 32'hD5);
    rst = 1'b1;
    #1;
    check("mrst_data",  32'(rx_data),  32'd0);
    check("mrst_valid", 32'(rx_valid), 32'd0);
    check("mrst_end",   32'(rx_end),   32'd0);
    rmii_crs_dv = 1'b0;
    rmii_rxd    = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    check_frame("mrst", 2, 32'h0000D555, 0, 1'b0, 4, -1);
    clear_q();
    preamble();
    byte_tx(8'h55); byte_tx(8'hD5); byte_tx(8'hA3);
    dib(2'b00, 1'b0); dib(2'b00, 1'b0);
    idle(4);
    check_frame("rst_next", 3, 32'h00A3D555, 1, 1'b0, 4, 2);

    check("coincident", 32'(n_coinc), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
